wb_slave_port_arbiter: RTL and testbench

//  Per-slave-port arbiter for the N-master Wishbone interconnect. Picks one owner among masters whose

---
 rtl/wb_ic_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 41 ++++
 rtl/wb_slave_port_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_slave_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types and sizing helpers for the Wishbone interconnect arbiters.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_ABORT
  } wb_arb_state_e;

  // Width of an encoded master index; a single master still needs one bit.
  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the watchdog counter; a disabled watchdog keeps a one-bit stub.
  function automatic int wdog_bits(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: the first eligible request at or after last+1 wins.
module wb_rr_pick import wb_ic_pkg::*; #(
  parameter  int N       = 3,
  localparam int ID_BITS = id_bits(N)
) (
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       mask,
  input  logic [ID_BITS-1:0] last,
  output logic [N-1:0]       onehot,
  output logic [ID_BITS-1:0] id,
  output logic               any
);

  logic [N-1:0] elig;
  int           best_idx;
  int           best_rank;
  int           rank;

  assign elig = req & ~mask;

  // Rank every eligible master by its distance after last and keep the closest.
  always_comb begin
    onehot    = '0;
    best_idx  = 0;
    best_rank = N;
    rank      = 0;
    for (int i = 0; i < N; i++) begin
      rank = (i + 2 * N - int'(last) - 1) % N;
      if (elig[i] && (rank < best_rank)) begin
        best_rank = rank;
        best_idx  = i;
      end
    end
    any = (best_rank < N);
    id  = ID_BITS'(best_idx);
    for (int i = 0; i < N; i++) begin
      onehot[i] = any && (i == best_idx);
    end
  end

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// Per-slave arbiter: round-robin burst ownership with a stalled-access watchdog.
module wb_slave_port_arbiter import wb_ic_pkg::*; #(
  parameter  int N_MASTERS = 3,
  parameter  int TIMEOUT   = 256,
  localparam int ID_BITS   = id_bits(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] stb,
  input  logic                 s_ack,
  input  logic                 s_err,
  output logic [N_MASTERS-1:0] gnt,
  output logic [ID_BITS-1:0]   gnt_id,
  output logic                 gnt_valid,
  output logic                 to_err
);

  localparam int WDOG_BITS = wdog_bits(TIMEOUT);
  localparam logic [WDOG_BITS-1:0] WDOG_FIRE = WDOG_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDOG_BITS-1:0] WDOG_MAX  = WDOG_BITS'(TIMEOUT);

  wb_arb_state_e          state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [ID_BITS-1:0]     owner_q, owner_d;
  logic [ID_BITS-1:0]     last_q, last_d;
  logic [WDOG_BITS-1:0]   wdog_q, wdog_d;
  logic                   gnt_valid_q, gnt_valid_d;
  logic                   to_err_q, to_err_d;

  logic                   owner_req;
  logic                   owner_stb;
  logic                   slave_done;
  logic                   arbitrate;
  logic                   is_idle;
  logic [N_MASTERS-1:0]   pick_mask;
  logic [ID_BITS-1:0]     pick_last;
  logic [N_MASTERS-1:0]   pick_onehot;
  logic [ID_BITS-1:0]     pick_id;
  logic                   pick_any;

  // The grant vector is one-hot on the owner, so it selects the owner's own req/stb.
  assign owner_req  = |(req & gnt_q);
  assign owner_stb  = |(stb & gnt_q);
  assign slave_done = s_ack | s_err;
  assign is_idle    = (state_q == ARB_IDLE);
  assign arbitrate  = is_idle || !owner_req;
  assign pick_mask  = is_idle ? '0 : gnt_q;
  assign pick_last  = is_idle ? last_q : owner_q;

  wb_rr_pick #(
    .N (N_MASTERS)
  ) u_pick (
    .req    (req),
    .mask   (pick_mask),
    .last   (pick_last),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  // Next-state logic: arbitrate on idle/release, otherwise hold the owner and run the watchdog.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdog_d      = wdog_q;
    gnt_valid_d = gnt_valid_q;
    to_err_d    = 1'b0;
    if (arbitrate) begin
      wdog_d = '0;
      if (!is_idle) begin
        last_d = owner_q;
      end
      if (pick_any) begin
        state_d     = ARB_OWNED;
        gnt_d       = pick_onehot;
        owner_d     = pick_id;
        gnt_valid_d = 1'b1;
      end else begin
        state_d     = ARB_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    end else if (state_q == ARB_ABORT) begin
      state_d = ARB_OWNED;
      wdog_d  = '0;
    end else if (!owner_stb || slave_done) begin
      wdog_d = '0;
    end else if ((TIMEOUT > 0) && (wdog_q == WDOG_FIRE)) begin
      state_d  = ARB_ABORT;
      wdog_d   = '0;
      to_err_d = 1'b1;
      last_d   = owner_q;
    end else if ((TIMEOUT > 0) && (wdog_q != WDOG_MAX)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // State, grant and watchdog registers; reset leaves master 0 with top priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      last_q      <= ID_BITS'(N_MASTERS - 1);
      wdog_q      <= '0;
      gnt_valid_q <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      gnt_valid_q <= gnt_valid_d;
      to_err_q    <= to_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = owner_q;
  assign gnt_valid = gnt_valid_q;
  assign to_err    = to_err_q;

endmodule

// File: tb/tb_wb_slave_port_arbiter.sv
// Bench for wb_slave_port_arbiter: a 3-master port with a short watchdog and a single-master port.
module tb_wb_slave_port_arbiter;

   localparam int N  = 3;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] req;
   logic [N-1:0] stb;
   logic         s_ack;
   logic         s_err;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         gnt_valid;
   logic         to_err;

   logic         req1;
   logic         stb1;
   logic         gnt1;
   logic         gnt_id1;
   logic         gnt_valid1;
   logic         to_err1;

   int checks   = 0;
   int failures = 0;

   int mOwner;
   int mLast;
   int mStall;
   bit mAbort;
   bit mPrevReq1;

   wb_slave_port_arbiter #(
      .N_MASTERS (N),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .stb       (stb),
      .s_ack     (s_ack),
      .s_err     (s_err),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .to_err    (to_err)
   );

   wb_slave_port_arbiter #(
      .N_MASTERS (1),
      .TIMEOUT   (0)
   ) dutSingle (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req1),
      .stb       (stb1),
      .s_ack     (1'b0),
      .s_err     (1'b0),
      .gnt       (gnt1),
      .gnt_id    (gnt_id1),
      .gnt_valid (gnt_valid1),
      .to_err    (to_err1)
   );

   // Free-running clock shared by both ports.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model returns to its post-reset view: nobody owns, master 0 first.
   task automatic modelReset();
      mOwner    = -1;
      mLast     = N - 1;
      mStall    = 0;
      mAbort    = 1'b0;
      mPrevReq1 = 1'b0;
   endtask

   // Reference model: advance one clock given the inputs seen at that edge.
   task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] s, input logic a, input logic e);
      int cand;
      int c;
      bit keeps;
      keeps = (mOwner >= 0) && r[mOwner[1:0]];
      if (!keeps) begin
         if (mOwner >= 0) mLast = mOwner;
         cand = -1;
         for (int k = 1; k <= N; k++) begin
            c = (mLast + k) % N;
            if (cand < 0 && r[c[1:0]] && c != mOwner) cand = c;
         end
         mOwner = cand;
         mStall = 0;
         mAbort = 1'b0;
      end else if (mAbort) begin
         mAbort = 1'b0;
         mStall = 0;
      end else if (s[mOwner[1:0]] && !a && !e) begin
         mStall++;
         if (mStall == TO) begin
            mAbort = 1'b1;
            mStall = 0;
            mLast  = mOwner;
         end
      end else begin
         mStall = 0;
      end
   endtask

   // Compare both ports against the model after an edge.
   task automatic compareAll();
      logic [31:0] expGnt;
      expGnt = (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
      checkOutput("gnt", 32'(gnt), expGnt);
      checkOutput("gnt_valid", 32'(gnt_valid), 32'(mOwner >= 0));
      checkOutput("to_err", 32'(to_err), 32'(mAbort));
      if (mOwner >= 0) checkOutput("gnt_id", 32'(gnt_id), 32'(mOwner));
      checkOutput("n1_gnt", 32'(gnt1), 32'(mPrevReq1));
      checkOutput("n1_gnt_valid", 32'(gnt_valid1), 32'(mPrevReq1));
      checkOutput("n1_gnt_id", 32'(gnt_id1), 32'd0);
      checkOutput("n1_to_err", 32'(to_err1), 32'd0);
   endtask

   // Drive one cycle of inputs, let the edge happen, then check against the model.
   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] s,
                                input logic a, input logic e, input logic r1);
      req   = r;
      stb   = s;
      s_ack = a;
      s_err = e;
      req1  = r1;
      stb1  = 1'b1;
      @(posedge clk);
      modelStep(r, s, a, e);
      mPrevReq1 = r1;
      #1;
      compareAll();
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL sim_timeout: got running expected finished");
      $fatal(1, "[TB] time limit reached");
   end

   // Directed scenarios followed by a randomized run.
   initial begin
      int order [4];
      logic [N-1:0] reqv;
      logic         r1v;
      order = '{0, 1, 2, 0};

      rstn  = 1'b0;
      req   = '0;
      stb   = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      req1  = 1'b0;
      stb1  = 1'b1;
      modelReset();
      #12;
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
      checkOutput("rst_gnt_valid", 32'(gnt_valid), 32'd0);
      checkOutput("rst_to_err", 32'(to_err), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Basic grant and bubble-free handoff
      applyStimulus(3'b101, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_first", 32'(gnt), 32'd1);
      applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_handoff", 32'(gnt), 32'd4);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_idle", 32'(gnt_valid), 32'd0);

      // Round-robin with everybody requesting
      applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t2_owner0", 32'(gnt), 32'd1);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(3'b111, 3'(1 << order[n]), 1'b1, 1'b0, 1'b1);
         applyStimulus(3'b111, 3'(1 << order[n]), 1'b1, 1'b0, 1'b1);
         applyStimulus(3'b111 & ~3'(1 << order[n]), 3'b000, 1'b0, 1'b0, 1'b1);
         checkOutput("t2_rr_next", 32'(gnt), 32'd1 << order[n + 1]);
      end
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

      // Watchdog fires on the fifth stalled cycle, one cycle wide, grant held
      applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
      checkOutput("t3_grant", 32'(gnt), 32'd2);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
         checkOutput("t3_to_err", 32'(to_err), 32'(k == 4));
         checkOutput("t3_gnt_held", 32'(gnt), 32'd2);
      end

      // ACK on the firing cycle wins and restarts the count
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(3'b010, 3'b010, 1'(j == 4), 1'b0, 1'b1);
         checkOutput("t4_to_err", 32'(to_err), 32'(j == 8));
      end

      // Asynchronous reset in the middle of a burst
      applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t5_owned", 32'(gnt), 32'd2);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("t5_async_gnt", 32'(gnt), 32'd0);
      checkOutput("t5_async_valid", 32'(gnt_valid), 32'd0);
      checkOutput("t5_async_n1", 32'(gnt1), 32'd0);
      modelReset();
      #2;
      rstn = 1'b1;
      applyStimulus(3'b011, 3'b000, 1'b0, 1'b0, 1'b1);
      checkOutput("t5_prio_reset", 32'(gnt), 32'd1);

      // Randomized traffic with held request bursts
      reqv = 3'b011;
      r1v  = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         reqv = reqv ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
         if ($urandom_range(15) == 0) r1v = ~r1v;
         applyStimulus(reqv, 3'($urandom) | 3'($urandom),
                       1'($urandom_range(7) == 0), 1'($urandom_range(15) == 0), r1v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
